// File: rtl/riscv_pkg.sv
// Shared RISC-V control constants: FSM state encoding, major opcodes
// (instr[6:2]) and datapath mux selects, plus a legal-opcode helper.
package riscv_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_REG    = 5'b01100;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_IMM    = 5'b00100;

    localparam logic ADDR_SEL_PC  = 1'b0;
    localparam logic ADDR_SEL_ALU = 1'b1;
    localparam logic PC_SRC_PLUS4 = 1'b0;
    localparam logic PC_SRC_ALU   = 1'b1;

    // True for every opcode the multicycle core knows how to execute
    function automatic logic op_is_legal(input logic [4:0] op);
        case (op)
            OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR,
            OP_REG, OP_LUI, OP_AUIPC, OP_IMM: op_is_legal = 1'b1;
            default:                          op_is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Memory handshake between the control FSM (master) and the memory (slave).
interface multicycle_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic mem_addr_sel;
    logic mem_ready;

    modport master (output mem_req, output mem_we, output mem_addr_sel, input mem_ready);
    modport slave  (input mem_req, input mem_we, input mem_addr_sel, output mem_ready);
endinterface

// File: rtl/retire_counter.sv
// Free-running count of retired instructions, wraps naturally at all-ones.
module retire_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);
    logic [CNT_W-1:0] r_cnt;

    // Increment once per retire pulse; async clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_cnt <= '0;
        else if (i_inc) r_cnt <= r_cnt + CNT_W'(1);
    end

    assign o_cnt = r_cnt;
endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V control FSM. Only the state is registered; all strobes
// are decoded from state/opcode/mem_ready/branch_taken so a memory completion
// is acted on in the same cycle it arrives. Outputs are gated by reset so an
// access in flight drops the moment reset asserts.
module multicycle_ctrl
    import riscv_pkg::*;
#(
    parameter int OPC_W = 5,
    parameter int CNT_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPC_W-1:0]    opcode,
    input  logic                branch_taken,
    multicycle_ctrl_if.master   mem,
    output logic                ir_write,
    output logic                alu_latch,
    output logic                pc_write,
    output logic                pc_src,
    output logic                reg_write,
    output logic                retire,
    output logic [CNT_W-1:0]    retired_cnt,
    output logic                trap,
    output logic [2:0]          state
);
    state_t     r_state;
    logic [4:0] w_op;
    logic       w_is_mem, w_is_store, w_is_branch, w_is_jump;

    assign w_op        = opcode[4:0];
    assign w_is_store  = (w_op == OP_STORE);
    assign w_is_mem    = (w_op == OP_LOAD) || w_is_store;
    assign w_is_branch = (w_op == OP_BRANCH);
    assign w_is_jump   = (w_op == OP_JAL) || (w_op == OP_JALR);

    // State transitions; TRAP is only left through reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_FETCH;
        end else begin
            case (r_state)
                ST_FETCH:  if (mem.mem_ready) r_state <= ST_DECODE;
                ST_DECODE: r_state <= op_is_legal(w_op) ? ST_EXEC : ST_TRAP;
                ST_EXEC: begin
                    if (w_is_branch)   r_state <= ST_FETCH;
                    else if (w_is_mem) r_state <= ST_MEM;
                    else               r_state <= ST_WB;
                end
                ST_MEM:    if (mem.mem_ready) r_state <= w_is_store ? ST_FETCH : ST_WB;
                ST_WB:     r_state <= ST_FETCH;
                ST_TRAP:   r_state <= ST_TRAP;
                default:   r_state <= ST_FETCH;
            endcase
        end
    end

    // Strobe decode; everything idle while reset is held
    always_comb begin
        mem.mem_req      = 1'b0;
        mem.mem_we       = 1'b0;
        mem.mem_addr_sel = ADDR_SEL_PC;
        ir_write         = 1'b0;
        alu_latch        = 1'b0;
        pc_write         = 1'b0;
        pc_src           = PC_SRC_PLUS4;
        reg_write        = 1'b0;
        retire           = 1'b0;
        trap             = 1'b0;
        if (!reset) begin
            case (r_state)
                ST_FETCH: begin
                    mem.mem_req = 1'b1;
                    ir_write    = mem.mem_ready;
                end
                ST_EXEC: begin
                    if (w_is_branch) begin
                        pc_write = 1'b1;
                        pc_src   = branch_taken;
                        retire   = 1'b1;
                    end else begin
                        alu_latch = 1'b1;
                    end
                end
                ST_MEM: begin
                    mem.mem_req      = 1'b1;
                    mem.mem_we       = w_is_store;
                    mem.mem_addr_sel = ADDR_SEL_ALU;
                    if (mem.mem_ready && w_is_store) begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                    end
                end
                ST_WB: begin
                    reg_write = 1'b1;
                    pc_write  = 1'b1;
                    pc_src    = w_is_jump ? PC_SRC_ALU : PC_SRC_PLUS4;
                    retire    = 1'b1;
                end
                ST_TRAP:  trap = 1'b1;
                default: ;
            endcase
        end
    end

    assign state = r_state;

    retire_counter #(.CNT_W(CNT_W)) u_retire_counter (
        .clk   (clk),
        .reset (reset),
        .i_inc (retire),
        .o_cnt (retired_cnt)
    );
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl. The driver walks each instruction
// through its expected phases, pushing one expected output snapshot per cycle
// and one expected pre-increment count per retire; a negedge monitor pops
// and compares. A narrow counter makes wrap-around happen in the random run.
module tb_multicycle_ctrl;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [4:0]    opcode = 5'b0;
    logic          branch_taken = 1'b0;
    logic          ir_write, alu_latch, pc_write, pc_src, reg_write, retire, trap;
    logic [CW-1:0] retired_cnt;
    logic [2:0]    state;

    multicycle_ctrl_if mif ();

    multicycle_ctrl #(.OPC_W(5), .CNT_W(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .opcode       (opcode),
        .branch_taken (branch_taken),
        .mem          (mif),
        .ir_write     (ir_write),
        .alu_latch    (alu_latch),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .reg_write    (reg_write),
        .retire       (retire),
        .retired_cnt  (retired_cnt),
        .trap         (trap),
        .state        (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic mreq, mwe, masel, irw, alul, pcw, pcs, rw, ret, trp;
    } obs_t;

    obs_t exp_q[$];
    int   ret_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   model_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic obs_t mk(input logic [2:0] st);
        obs_t o;
        o = '0;
        o.st = st;
        return o;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // One clock cycle: drive inputs, record what the outputs must be, advance
    task automatic step(input logic mr, input logic bt, input obs_t e);
        mif.mem_ready = mr;
        branch_taken  = bt;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic expect_retire();
        ret_q.push_back(model_cnt);
        model_cnt = (model_cnt + 1) % (1 << CW);
    endtask

    // Reference behaviour of one instruction: fw/mw are memory wait cycles
    task automatic issue(input logic [4:0] op, input int fw, input int mw,
                         input logic bt, input bit abort_mem);
        obs_t e;
        bit legal, is_st, is_mem, is_br, is_j;
        legal  = op inside {5'b00000, 5'b01000, 5'b11000, 5'b11011, 5'b11001,
                            5'b01100, 5'b01101, 5'b00101, 5'b00100};
        is_st  = (op == 5'b01000);
        is_mem = is_st || (op == 5'b00000);
        is_br  = (op == 5'b11000);
        is_j   = (op == 5'b11011) || (op == 5'b11001);
        opcode = op;
        for (int i = 0; i <= fw; i++) begin
            e = mk(3'd0); e.mreq = 1'b1; e.irw = (i == fw);
            step(i == fw, rb(), e);
        end
        e = mk(3'd1);
        step(rb(), rb(), e);
        if (!legal) return;
        e = mk(3'd2);
        if (is_br) begin
            e.pcw = 1'b1; e.pcs = bt; e.ret = 1'b1;
            expect_retire();
            step(rb(), bt, e);
            return;
        end
        e.alul = 1'b1;
        step(rb(), rb(), e);
        if (is_mem) begin
            for (int i = 0; i <= mw; i++) begin
                e = mk(3'd3); e.mreq = 1'b1; e.masel = 1'b1; e.mwe = is_st;
                if (abort_mem && i == 1) begin
                    mif.mem_ready = 1'b0;
                    exp_q.push_back(e);
                    #6;
                    reset = 1'b1;
                    #1;
                    chk("rst_mem_req", 32'(mif.mem_req), 32'd0);
                    chk("rst_mem_we", 32'(mif.mem_we), 32'd0);
                    chk("rst_state", 32'(state), 32'd0);
                    chk("rst_cnt", 32'(retired_cnt), 32'd0);
                    @(posedge clk);
                    #1;
                    reset = 1'b0;
                    model_cnt = 0;
                    return;
                end
                if (i == mw && is_st) begin
                    e.pcw = 1'b1; e.ret = 1'b1;
                    expect_retire();
                end
                step(i == mw, rb(), e);
            end
        end
        if (!is_st) begin
            e = mk(3'd4); e.rw = 1'b1; e.pcw = 1'b1; e.pcs = is_j; e.ret = 1'b1;
            expect_retire();
            step(rb(), rb(), e);
        end
    endtask

    // Monitor: compare the full output snapshot every cycle, and the counter on each retire
    always @(negedge clk) begin
        obs_t a, e;
        if (!reset) begin
            a = {state, mif.mem_req, mif.mem_we, mif.mem_addr_sel, ir_write, alu_latch,
                 pc_write, pc_src, reg_write, retire, trap};
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("cycle_outputs", 32'(a), 32'(e));
            end
            if (retire) begin
                chk("retire_expected", 32'(ret_q.size() > 0), 32'd1);
                if (ret_q.size() > 0) chk("retired_cnt", 32'(retired_cnt), 32'(ret_q.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        obs_t e;
        mif.mem_ready = 1'b0;
        #2;
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_mem_req", 32'(mif.mem_req), 32'd0);
        chk("reset_trap", 32'(trap), 32'd0);
        chk("reset_cnt", 32'(retired_cnt), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        issue(5'b00100, 0, 0, 1'b0, 0);          // ADDI
        chk("addi_cnt", 32'(retired_cnt), 32'(model_cnt));
        issue(5'b00000, 0, 3, 1'b0, 0);          // LW, 3 wait cycles in MEM
        issue(5'b11000, 0, 0, 1'b1, 0);          // BEQ taken
        issue(5'b11000, 1, 0, 1'b0, 0);          // BEQ not taken
        issue(5'b01000, 0, 0, 1'b0, 0);          // SW
        issue(5'b11011, 0, 0, 1'b0, 0);          // JAL
        issue(5'b11001, 2, 1, 1'b0, 0);          // JALR

        for (int n = 0; n < 40; n++) begin
            logic [4:0] ops [9];
            ops = '{5'b00000, 5'b01000, 5'b11000, 5'b11011, 5'b11001,
                    5'b01100, 5'b01101, 5'b00101, 5'b00100};
            issue(ops[$urandom_range(0, 8)], $urandom_range(0, 2), $urandom_range(0, 3), rb(), 0);
        end
        chk("cnt_after_random", 32'(retired_cnt), 32'(model_cnt));

        issue(5'b01000, 0, 3, 1'b0, 1);          // SW aborted by reset mid-wait
        issue(5'b00100, 0, 0, 1'b0, 0);          // first request after reset is a fetch
        chk("cnt_after_abort", 32'(retired_cnt), 32'(model_cnt));

        issue(5'b11100, 1, 0, 1'b0, 0);          // illegal opcode
        for (int i = 0; i < 4; i++) begin
            e = mk(3'd5); e.trp = 1'b1;
            step(rb(), rb(), e);
        end
        chk("trap_cnt", 32'(retired_cnt), 32'(model_cnt));
        reset = 1'b1;
        #1;
        chk("trap_rst_state", 32'(state), 32'd0);
        chk("trap_rst_trap", 32'(trap), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_cnt = 0;
        issue(5'b01100, 0, 0, 1'b0, 0);          // REG after trap recovery

        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        chk("ret_q_drained", 32'(ret_q.size()), 32'd0);
        chk("final_cnt", 32'(retired_cnt), 32'(model_cnt));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have the parameter OPC_W, default 5, width of the opcode field (instr[6:2]).
REQ-002 The block SHALL have the parameter CNT_W, default 32, width of the retired-instruction counter.
REQ-003 The block SHALL have the port clk, input, 1, the single clock, rising-edge.
REQ-004 The block SHALL have the port reset, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have the port opcode, input, OPC_W, the latched instruction's instr[6:2], valid from DECODE onward.
REQ-006 The block SHALL have the port branch_taken, input, 1, the branch comparator result, sampled only in EXEC.
REQ-007 The block SHALL have the port mem_ready, input, 1, the memory completion strobe.
REQ-008 The block SHALL have the port mem_req, output, 1, the memory access request.
REQ-009 The block SHALL have the port mem_we, output, 1, the memory write enable, qualified by mem_req.
REQ-010 The block SHALL have the port mem_addr_sel, output, 1, selecting the address source (0=PC, 1=ALU result register).
REQ-011 The block SHALL have the port ir_write, output, 1, the instruction register load strobe.
REQ-012 The block SHALL have the port alu_latch, output, 1, the ALU result register load strobe.
REQ-013 The block SHALL have the port pc_write, output, 1, the PC update strobe.
REQ-014 The block SHALL have the port pc_src, output, 1, selecting the PC source (0=PC+4, 1=ALU result).
REQ-015 The block SHALL have the port reg_write, output, 1, the register file write strobe.
REQ-016 The block SHALL have the port retire, output, 1, a one-cycle pulse per completed instruction.
REQ-017 The block SHALL have the port retired_cnt, output, CNT_W, the count of retired instructions.
REQ-018 The block SHALL have the port trap, output, 1, set high while in TRAP.
REQ-019 The block SHALL have the port state, output, 3, the current FSM state for debug.

Function
REQ-020 The FSM SHALL have the states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4 and TRAP=5.
REQ-021 All outputs SHALL be Moore/Mealy combinational decodes of state, opcode, mem_ready and branch_taken, except retired_cnt, which is registered.
REQ-022 In FETCH, the block SHALL drive mem_req=1, mem_we=0 and mem_addr_sel=0, and stay in FETCH while mem_ready=0; when mem_ready=1 it SHALL drive ir_write=1 in that cycle and go to DECODE.
REQ-023 In DECODE, the block SHALL go to EXEC when opcode is one of LOAD 00000, STORE 01000, BRANCH 11000, JAL 11011, JALR 11001, REG 01100, LUI 01101, AUIPC 00101 or IMM 00100, and SHALL go to TRAP for any other opcode.
REQ-024 In EXEC, the block SHALL drive alu_latch=1 and then go to MEM for LOAD/STORE and to WB for REG, IMM, LUI, AUIPC, JAL and JALR.
REQ-025 For BRANCH in EXEC, the block SHALL drive pc_write=1, pc_src=branch_taken and retire=1, and go to FETCH.
REQ-026 In MEM, the block SHALL drive mem_req=1, mem_addr_sel=1 and mem_we=1 (STORE only), and hold until mem_ready=1.
REQ-027 On mem_ready in MEM, a STORE SHALL drive pc_write=1, pc_src=0 and retire=1 and go to FETCH, and a LOAD SHALL go to WB.
REQ-028 In WB, the block SHALL drive reg_write=1, pc_write=1 and retire=1, with pc_src=1 for JAL/JALR and 0 otherwise, and go to FETCH.
REQ-029 In TRAP, all strobes SHALL be 0 and trap=1, and the FSM SHALL stay in TRAP until reset.
REQ-030 mem_req, mem_we and mem_addr_sel SHALL stay stable from assertion until the cycle in which mem_ready=1 inclusive.
REQ-031 mem_ready SHALL be ignored outside FETCH and MEM.
REQ-032 At most one of ir_write, alu_latch and reg_write SHALL be high in any cycle.
REQ-033 pc_write SHALL be high exactly once per retired instruction.
REQ-034 Latency with zero-wait memory SHALL be: BRANCH 3 cycles, ALU/JAL/JALR 4, STORE 4, LOAD 5.
REQ-035 retired_cnt SHALL increment by 1 on each cycle in which retire=1, and SHALL wrap from all-ones to 0.

Reset
REQ-036 Asserting reset SHALL immediately force state to FETCH and retired_cnt to 0, irrespective of clk.
REQ-037 While reset=1, all strobes, mem_req and trap SHALL be 0.
REQ-038 Reset asserted mid-access (FETCH or MEM) SHALL abandon the access, and the first request after reset release SHALL be a FETCH.

Structure
REQ-039 Opcode constants SHALL live in a shared package riscv_pkg, reused by the instruction decoder.
REQ-040 State encodings and mux-select constants SHALL live in the same package, riscv_pkg.
REQ-041 The retired-instruction counter SHALL be a sub-module, retire_counter.

Verification
REQ-042 With ADDI (opcode 00100) and zero-wait memory, the bench SHALL see the state sequence 0,1,2,4,0, one reg_write, one pc_write with pc_src=0, and retired_cnt 0->1.
REQ-043 With LW and mem_ready held low for 3 cycles in MEM, the bench SHALL see mem_req=1 and mem_addr_sel=1 held stable for 4 cycles, then WB, for 8 cycles total.
REQ-044 With BEQ and branch_taken=1, the bench SHALL see pc_write=1 and pc_src=1 in EXEC and no reg_write; with branch_taken=0 it SHALL see pc_src=0.
REQ-045 With opcode 11100 in DECODE, the bench SHALL see TRAP, trap=1, no further mem_req and retired_cnt unchanged, and reset SHALL return the FSM to FETCH.
REQ-046 With reset pulsed while in MEM during a store wait, the bench SHALL see mem_req and mem_we drop asynchronously, state 0, and retired_cnt 0.
REQ-047 With retired_cnt forced near all-ones, two ADDI retires SHALL show the counter wrapping to 0.
